// File: rtl/fifo_read_operation_pkg.sv
// ----------------------------------------------------------------------------
// fifo_read_operation_pkg
//   Constants and the read-side FSM encoding shared by the 8-entry register
//   FIFO read and write paths.
// ----------------------------------------------------------------------------
package fifo_read_operation_pkg;

    localparam int unsigned FIFO_DATA_W = 32;
    localparam int unsigned FIFO_DEPTH  = 8;
    localparam int unsigned FIFO_ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        READ   = 2'b01,
        RD_ERR = 2'b10
    } rd_state_t;

endpackage : fifo_read_operation_pkg

// File: rtl/fifo_read_operation_read_mux.sv
// ----------------------------------------------------------------------------
// read_mux_8to1
//   Combinational DEPTH:1 selector returning the FIFO entry addressed by sel.
// Ports
//   reg_flat  in   DEPTH*DATA_W  flattened register bank, entry i at [i*DATA_W +: DATA_W]
//   sel       in   ADDR_W        entry index
//   data      out  DATA_W        selected entry
// ----------------------------------------------------------------------------
module read_mux_8to1
    import fifo_read_operation_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W,
    parameter int unsigned DEPTH  = FIFO_DEPTH,
    parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
    input  logic [DEPTH*DATA_W-1:0] reg_flat,
    input  logic [ADDR_W-1:0]       sel,
    output logic [DATA_W-1:0]       data
);

    always_comb begin
        data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sel == ADDR_W'(i)) begin
                data = reg_flat[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule : read_mux_8to1

// File: rtl/fifo_read_operation.sv
// ----------------------------------------------------------------------------
// fifo_read_operation
//   Read-side controller of the 8-entry register FIFO. Owns the head pointer
//   and occupancy count, selects the head entry and returns registered data
//   with a one-cycle ack (read done) or err (read while empty) pulse.
// Ports
//   clk       in   1             clock, rising edge
//   reset     in   1             asynchronous active-high reset
//   re        in   1             read request
//   we        in   1             write strobe from write side (count tracking only)
//   reg_flat  in   DEPTH*DATA_W  register bank contents
//   rd_addr   out  ADDR_W        head pointer
//   dout      out  DATA_W        registered read data
//   rd_ack    out  1             read completed, dout valid this cycle
//   rd_err    out  1             read rejected, FIFO was empty
//   count     out  ADDR_W+1      occupancy 0..DEPTH
//   empty     out  1             count == 0
//   full      out  1             count == DEPTH
// ----------------------------------------------------------------------------
module fifo_read_operation
    import fifo_read_operation_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W,
    parameter int unsigned DEPTH  = FIFO_DEPTH,
    parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    re,
    input  logic                    we,
    input  logic [DEPTH*DATA_W-1:0] reg_flat,
    output logic [ADDR_W-1:0]       rd_addr,
    output logic [DATA_W-1:0]       dout,
    output logic                    rd_ack,
    output logic                    rd_err,
    output logic [ADDR_W:0]         count,
    output logic                    empty,
    output logic                    full
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    rd_state_t           state_q, state_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [DATA_W-1:0]   head_data;
    logic                rd_valid;
    logic                wr_valid;

    read_mux_8to1 #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_read_mux (
        .reg_flat (reg_flat),
        .sel      (rd_ptr_q),
        .data     (head_data)
    );

    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign rd_valid = re & ~empty;
    assign wr_valid = we & ~full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    always_comb begin
        state_d  = IDLE;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;

        if (re) begin
            state_d = empty ? RD_ERR : READ;
        end

        // DEPTH == 2**ADDR_W, so natural overflow gives the 7 -> 0 wrap.
        if (rd_valid) begin
            dout_d   = head_data;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // wr_valid/rd_valid already exclude overflow and underflow.
        unique case ({wr_valid, rd_valid})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    assign rd_ack  = (state_q == READ);
    assign rd_err  = (state_q == RD_ERR);
    assign rd_addr = rd_ptr_q;
    assign dout    = dout_q;
    assign count   = count_q;

endmodule : fifo_read_operation

// File: tb/tb_fifo_read_operation.sv
module tb_fifo_read_operation;

    localparam int unsigned DW = 32;
    localparam int unsigned DP = 8;
    localparam int unsigned AW = 3;

    logic               clk;
    logic               reset;
    logic               re;
    logic               we;
    logic               bw;
    logic [DP*DW-1:0]   reg_flat;
    logic [AW-1:0]      rd_addr;
    logic [DW-1:0]      dout;
    logic               rd_ack;
    logic               rd_err;
    logic [AW:0]        count;
    logic               empty;
    logic               full;

    fifo_read_operation #(
        .DATA_W (DW),
        .DEPTH  (DP),
        .ADDR_W (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .re       (re),
        .we       (we),
        .reg_flat (reg_flat),
        .rd_addr  (rd_addr),
        .dout     (dout),
        .rd_ack   (rd_ack),
        .rd_err   (rd_err),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in register bank: write number n (1-based since reset) stores 0x11*n at the tail.
    logic [DW-1:0] mem [DP] = '{default: '0};
    logic [AW-1:0] wp;
    logic [31:0]   wcnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wp   <= '0;
            wcnt <= '0;
        end else if (bw) begin
            mem[wp] <= 32'h11 * (wcnt + 1);
            wp      <= wp + 1'b1;
            wcnt    <= wcnt + 1;
        end
    end

    always_comb begin
        reg_flat = '0;
        for (int i = 0; i < DP; i++) reg_flat[i*DW +: DW] = mem[i];
    end

    typedef struct {
        logic        rst;
        logic        re;
        logic        we;
        logic        bw;
        logic        ack;
        logic        err;
        logic [31:0] dout;
        logic [3:0]  cnt;
        logic [2:0]  addr;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cur   = -1;

    function automatic void add(int rst_v, int re_v, int we_v, int bw_v,
                                int ack_v, int err_v, int dout_v, int cnt_v, int addr_v);
        vec_t v;
        v.rst  = rst_v[0];
        v.re   = re_v[0];
        v.we   = we_v[0];
        v.bw   = bw_v[0];
        v.ack  = ack_v[0];
        v.err  = err_v[0];
        v.dout = dout_v;
        v.cnt  = cnt_v[3:0];
        v.addr = addr_v[2:0];
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (vec %0d): got %0h expected %0h", name, cur, act, exp);
        end
    endtask

    task automatic chk_all(input logic ack, input logic err, input logic [31:0] d,
                           input logic [3:0] c, input logic [2:0] a);
        chk("rd_ack",  {31'b0, rd_ack}, {31'b0, ack});
        chk("rd_err",  {31'b0, rd_err}, {31'b0, err});
        chk("dout",    dout, d);
        chk("count",   {28'b0, count}, {28'b0, c});
        chk("rd_addr", {29'b0, rd_addr}, {29'b0, a});
        chk("empty",   {31'b0, empty}, {31'b0, (c == 4'd0)});
        chk("full",    {31'b0, full},  {31'b0, (c == 4'd8)});
    endtask

    initial begin
        // Read on empty -> err, then idle
        add(0,1,0,0, 0,1,0,0,0);
        add(0,0,0,0, 0,0,0,0,0);
        // Three writes, three reads
        add(0,0,1,1, 0,0,0,1,0);
        add(0,0,1,1, 0,0,0,2,0);
        add(0,0,1,1, 0,0,0,3,0);
        add(0,1,0,0, 1,0,'h11,2,1);
        add(0,1,0,0, 1,0,'h22,1,2);
        add(0,1,0,0, 1,0,'h33,0,3);
        add(0,0,0,0, 0,0,'h33,0,3);
        add(1,0,0,0, 0,0,0,0,0);
        // Fill to 8, extra write ignored, drain 8 with wrap
        for (int k = 1; k <= 8; k++) add(0,0,1,1, 0,0,0,k,0);
        add(0,0,1,0, 0,0,0,8,0);
        for (int k = 1; k <= 8; k++) add(0,1,0,0, 1,0,'h11*k,8-k,k%8);
        add(0,0,0,0, 0,0,'h88,0,0);
        // count=4, simultaneous write+read for 5 cycles, then drain
        for (int k = 1; k <= 4; k++) add(0,0,1,1, 0,0,'h88,k,0);
        add(0,1,1,1, 1,0,'h99,4,1);
        add(0,1,1,1, 1,0,'hAA,4,2);
        add(0,1,1,1, 1,0,'hBB,4,3);
        add(0,1,1,1, 1,0,'hCC,4,4);
        add(0,1,1,1, 1,0,'hDD,4,5);
        add(0,1,0,0, 1,0,'hEE,3,6);
        add(0,1,0,0, 1,0,'hFF,2,7);
        add(0,1,0,0, 1,0,'h110,1,0);
        add(0,1,0,0, 1,0,'h121,0,1);
        // Write+read on empty: err, count +1; then read succeeds; then empty read
        add(0,1,1,1, 0,1,'h121,1,1);
        add(0,1,0,0, 1,0,'h132,0,2);
        add(0,1,0,0, 0,1,'h132,0,2);
        add(0,0,0,0, 0,0,'h132,0,2);

        reset = 1'b1; re = 1'b0; we = 1'b0; bw = 1'b0;
        #12;
        chk_all(1'b0, 1'b0, 32'h0, 4'd0, 3'd0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            cur   = i;
            reset = vecs[i].rst;
            re    = vecs[i].re;
            we    = vecs[i].we;
            bw    = vecs[i].bw;
            @(posedge clk);
            #1;
            chk_all(vecs[i].ack, vecs[i].err, vecs[i].dout, vecs[i].cnt, vecs[i].addr);
            reset = 1'b0;
        end

        // Reset asserted while an ack pulse is in flight clears everything at once
        cur = 1000;
        re = 1'b0; we = 1'b1; bw = 1'b1;
        @(posedge clk); #1;
        chk("pre_count", {28'b0, count}, 32'd1);
        re = 1'b1; we = 1'b0; bw = 1'b0;
        @(posedge clk); #1;
        chk("pre_ack",  {31'b0, rd_ack}, 32'd1);
        chk("pre_dout", dout, 32'h143);
        re = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk_all(1'b0, 1'b0, 32'h0, 4'd0, 3'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk_all(1'b0, 1'b0, 32'h0, 4'd0, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fifo_read_operation
